// File: rtl/mac_accumulator_if.sv
// Stream interface of the MAC accumulator: product beats in, saturated dot-product result out.
// The master side is the upstream multiplier together with the result consumer; the slave side is the accumulator.
interface mac_accumulator_if #(
    parameter int PROD_BIT = 32,
    parameter int OUT_BIT  = 32,
    parameter int CNT_BIT  = 16
);
    logic                in_valid;
    logic                in_ready;
    logic [PROD_BIT-1:0] in_prod;
    logic                in_last;
    logic                out_valid;
    logic                out_ready;
    logic [OUT_BIT-1:0]  out_data;
    logic                out_sat;
    logic [CNT_BIT-1:0]  out_count;

    modport master (
        output in_valid, in_prod, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_sat, out_count
    );

    modport slave (
        input  in_valid, in_prod, in_last, out_ready,
        output in_ready, out_valid, out_data, out_sat, out_count
    );
endinterface

// File: rtl/mac_accumulator.sv
// Accumulates one vector of signed products into a wide accumulator and presents a
// 32-bit saturated sum, saturation flag and beat count over a valid/ready handshake.
module mac_accumulator #(
    parameter int PROD_BIT = 32,
    parameter int ACC_BIT  = 40,
    parameter int OUT_BIT  = 32,
    parameter int CNT_BIT  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    mac_accumulator_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    localparam logic signed [ACC_BIT-1:0] ACC_MAX = {1'b0, {(ACC_BIT-1){1'b1}}};
    localparam logic signed [ACC_BIT-1:0] ACC_MIN = {1'b1, {(ACC_BIT-1){1'b0}}};
    localparam logic signed [ACC_BIT-1:0] OUT_MAX_EXT = {{(ACC_BIT-OUT_BIT+1){1'b0}}, {(OUT_BIT-1){1'b1}}};
    localparam logic signed [ACC_BIT-1:0] OUT_MIN_EXT = {{(ACC_BIT-OUT_BIT+1){1'b1}}, {(OUT_BIT-1){1'b0}}};
    localparam logic [OUT_BIT-1:0] OUT_MAX = {1'b0, {(OUT_BIT-1){1'b1}}};
    localparam logic [OUT_BIT-1:0] OUT_MIN = {1'b1, {(OUT_BIT-1){1'b0}}};

    state_t                    state_q, state_d;
    logic signed [ACC_BIT-1:0] acc_q, acc_d;
    logic [CNT_BIT-1:0]        cnt_q, cnt_d;
    logic                      ovf_q, ovf_d;
    logic                      out_valid_q, out_valid_d;
    logic [OUT_BIT-1:0]        out_data_q, out_data_d;
    logic                      out_sat_q, out_sat_d;
    logic [CNT_BIT-1:0]        out_count_q, out_count_d;

    logic signed [ACC_BIT-1:0] prod_ext;
    logic signed [ACC_BIT-1:0] sum;
    logic                      add_ovf;
    logic                      in_ready;
    logic                      beat_fire;

    assign in_ready  = (state_q != HOLD);
    assign beat_fire = bus.in_valid && in_ready;
    assign prod_ext  = {{(ACC_BIT-PROD_BIT){bus.in_prod[PROD_BIT-1]}}, bus.in_prod};
    assign sum       = acc_q + prod_ext;
    // Two's-complement overflow: operands agree in sign but the sum does not.
    assign add_ovf   = (acc_q[ACC_BIT-1] == prod_ext[ACC_BIT-1]) && (sum[ACC_BIT-1] != acc_q[ACC_BIT-1]);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        out_count_d = out_count_q;

        if (clear) begin
            state_d     = IDLE;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_sat_d   = 1'b0;
            out_count_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (beat_fire) begin
                        acc_d   = prod_ext;
                        cnt_d   = CNT_BIT'(1);
                        ovf_d   = 1'b0;
                        state_d = bus.in_last ? HOLD : ACCUM;
                    end
                end
                ACCUM: begin
                    if (beat_fire) begin
                        if (ovf_q) begin
                            acc_d = acc_q;
                        end else if (add_ovf) begin
                            acc_d = prod_ext[ACC_BIT-1] ? ACC_MIN : ACC_MAX;
                            ovf_d = 1'b1;
                        end else begin
                            acc_d = sum;
                        end
                        cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_BIT'(1);
                        state_d = bus.in_last ? HOLD : ACCUM;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase

            // The result is registered from the freshly updated accumulator on the closing beat.
            if (beat_fire && bus.in_last) begin
                if (acc_d > OUT_MAX_EXT) begin
                    out_data_d = OUT_MAX;
                    out_sat_d  = 1'b1;
                end else if (acc_d < OUT_MIN_EXT) begin
                    out_data_d = OUT_MIN;
                    out_sat_d  = 1'b1;
                end else begin
                    out_data_d = acc_d[OUT_BIT-1:0];
                    out_sat_d  = ovf_d;
                end
                out_count_d = cnt_d;
                out_valid_d = 1'b1;
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            out_count_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            out_count_q <= out_count_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sat   = out_sat_q;
    assign bus.out_count = out_count_q;
endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator: hand-computed vectors covering handshake,
// saturation, accumulator overflow, clear and asynchronous reset.
module tb_mac_accumulator;
    logic clk;
    logic rst_n;
    logic clear;
    int   n_cmp;
    int   n_err;

    mac_accumulator_if #(.PROD_BIT(32), .OUT_BIT(32), .CNT_BIT(16)) bus ();

    mac_accumulator #(
        .PROD_BIT(32), .ACC_BIT(40), .OUT_BIT(32), .CNT_BIT(16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    // Present one beat, let it be sampled on the next edge, then withdraw it 1 ns later.
    task automatic beat(input logic [31:0] p, input logic l);
        bus.in_valid = 1'b1;
        bus.in_prod  = p;
        bus.in_last  = l;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic check_result(input string name, input logic [31:0] data,
                                input logic sat, input logic [15:0] cnt);
        n_cmp++;
        if (bus.out_valid !== 1'b1) begin
            n_err++; $display("FAIL %s_valid: got %b expected 1", name, bus.out_valid);
        end
        n_cmp++;
        if (bus.out_data !== data) begin
            n_err++; $display("FAIL %s_data: got %h expected %h", name, bus.out_data, data);
        end
        n_cmp++;
        if (bus.out_sat !== sat) begin
            n_err++; $display("FAIL %s_sat: got %b expected %b", name, bus.out_sat, sat);
        end
        n_cmp++;
        if (bus.out_count !== cnt) begin
            n_err++; $display("FAIL %s_count: got %0d expected %0d", name, bus.out_count, cnt);
        end
    endtask

    task automatic test_reset;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 32'd0 || bus.out_sat !== 1'b0 ||
            bus.out_count !== 16'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got v=%b d=%h s=%b c=%0d expected all zero",
                     bus.out_valid, bus.out_data, bus.out_sat, bus.out_count);
        end
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
        end
    endtask

    task automatic test_basic;
        bus.out_ready = 1'b1;
        beat(32'd100, 1'b0);
        beat(-32'sd250, 1'b0);
        beat(32'd7, 1'b1);
        check_result("basic", 32'hFFFFFF71, 1'b0, 16'd3);
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin
            n_err++; $display("FAIL basic_ready_hold: got %b expected 0", bus.in_ready);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL basic_after_xfer: got v=%b r=%b expected v=0 r=1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_backpressure;
        bus.out_ready = 1'b0;
        beat(32'd100, 1'b0);
        beat(-32'sd250, 1'b0);
        beat(32'd7, 1'b1);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = i[0] ? 1'b0 : 1'b1;
            bus.in_prod  = 32'd999;
            bus.in_last  = 1'b1;
            n_cmp++;
            if (bus.in_ready !== 1'b0) begin
                n_err++; $display("FAIL bp_ready_%0d: got %b expected 0", i, bus.in_ready);
            end
            check_result("bp_stable", 32'hFFFFFF71, 1'b0, 16'd3);
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_release: got v=%b r=%b expected v=0 r=1", bus.out_valid, bus.in_ready);
        end
        beat(32'd5, 1'b0);
        beat(32'd5, 1'b1);
        check_result("bp_next", 32'd10, 1'b0, 16'd2);
        @(posedge clk); #1;
    endtask

    task automatic test_saturation;
        bus.out_ready = 1'b1;
        beat(32'h7FFFFFFF, 1'b0);
        beat(32'h7FFFFFFF, 1'b1);
        check_result("sat_pos", 32'h7FFFFFFF, 1'b1, 16'd2);
        @(posedge clk); #1;
        beat(32'h80000000, 1'b0);
        beat(32'h80000000, 1'b1);
        check_result("sat_neg", 32'h80000000, 1'b1, 16'd2);
        @(posedge clk); #1;
        for (int i = 0; i < 256; i++) beat(32'h7FFFFFFF, 1'b0);
        beat(32'h7FFFFFFF, 1'b1);
        check_result("acc_ovf", 32'h7FFFFFFF, 1'b1, 16'd257);
        @(posedge clk); #1;
    endtask

    task automatic test_single_beat;
        bus.out_ready = 1'b1;
        beat(32'hFFC00080, 1'b1);
        check_result("single", 32'hFFC00080, 1'b0, 16'd1);
        @(posedge clk); #1;
    endtask

    task automatic test_clear;
        bus.out_ready = 1'b1;
        beat(32'd10, 1'b0);
        beat(32'd20, 1'b0);
        clear        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_prod  = 32'd1000;
        bus.in_last  = 1'b1;
        @(posedge clk); #1;
        clear        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL clear_flush: got v=%b r=%b expected v=0 r=1", bus.out_valid, bus.in_ready);
        end
        beat(32'd1, 1'b0);
        beat(32'd2, 1'b1);
        check_result("clear_next", 32'd3, 1'b0, 16'd2);
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        beat(32'd4, 1'b1);
        check_result("clear_hold_pre", 32'd4, 1'b0, 16'd1);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 32'd0 || bus.out_sat !== 1'b0 ||
            bus.out_count !== 16'd0 || bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL clear_hold: got v=%b d=%h s=%b c=%0d r=%b expected zeros with r=1",
                     bus.out_valid, bus.out_data, bus.out_sat, bus.out_count, bus.in_ready);
        end
        bus.out_ready = 1'b1;
    endtask

    task automatic test_async_reset;
        bus.out_ready = 1'b1;
        beat(32'd9, 1'b1);
        check_result("rst_pre", 32'd9, 1'b0, 16'd1);
        @(posedge clk); #1;
        beat(32'd50, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 32'd0 || bus.out_count !== 16'd0 ||
            bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL async_reset: got v=%b d=%h c=%0d r=%b expected zeros with r=1",
                     bus.out_valid, bus.out_data, bus.out_count, bus.in_ready);
        end
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        beat(32'd4, 1'b1);
        check_result("rst_after", 32'd4, 1'b0, 16'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        rst_n         = 1'b0;
        clear         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_prod   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        #23;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_basic();
        test_backpressure();
        test_saturation();
        test_single_beat();
        test_clear();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
